// File: rtl/maxpool_stream.sv
// 2x2 stride-2 max pooling over a raster-order pixel stream with per-lane compare.
// A half-width line buffer holds the horizontal maxima of each even row until the odd row below arrives.
module maxpool_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int SIGNED     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  output logic                           i_ready,
  output logic                           o_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_data,
  output logic                           o_last,
  input  logic                           o_ready
);

  localparam int WORD   = CHANNELS * DATA_WIDTH;
  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0]   col_reg;
  logic [RW-1:0]   row_reg;
  logic [WORD-1:0] pair_reg;
  logic [WORD-1:0] lb_rd_reg;
  logic [WORD-1:0] lb_mem [0:HALF_W-1];
  logic [WORD-1:0] o_data_reg;
  logic            o_valid_reg;
  logic            o_last_reg;

  logic [WORD-1:0] hmax;
  logic [WORD-1:0] vmax;
  logic [AW-1:0]   lb_addr;
  logic            in_fire;
  logic            out_fire;
  logic            result_load;
  logic            col_last;
  logic            row_last;

  function automatic logic greater(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  assign i_ready     = !o_valid_reg || o_ready;
  assign in_fire     = i_valid && i_ready;
  assign out_fire    = o_valid_reg && o_ready;
  assign result_load = in_fire && row_reg[0] && col_reg[0];
  assign col_last    = (col_reg == CW'(IMG_W - 1));
  assign row_last    = (row_reg == RW'(IMG_H - 1));
  assign lb_addr     = AW'(col_reg >> 1);

  assign o_valid = o_valid_reg;
  assign o_data  = o_data_reg;
  assign o_last  = o_last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] in_l;
      logic [DATA_WIDTH-1:0] pair_l;
      logic [DATA_WIDTH-1:0] top_l;
      logic [DATA_WIDTH-1:0] hmax_l;

      assign in_l   = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign pair_l = pair_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign top_l  = lb_rd_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign hmax_l = greater(in_l, pair_l) ? in_l : pair_l;

      assign hmax[gi*DATA_WIDTH +: DATA_WIDTH] = hmax_l;
      assign vmax[gi*DATA_WIDTH +: DATA_WIDTH] = greater(top_l, hmax_l) ? top_l : hmax_l;
    end
  endgenerate

  // The line-buffer entry for an odd-row window is fetched on the even column,
  // so it is already registered when the bottom-right pixel arrives.
  always_ff @(posedge clk) begin
    if (in_fire && !row_reg[0] && col_reg[0]) lb_mem[lb_addr] <= hmax;
    if (in_fire && row_reg[0] && !col_reg[0]) lb_rd_reg <= lb_mem[lb_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg     <= '0;
      row_reg     <= '0;
      pair_reg    <= '0;
      o_data_reg  <= '0;
      o_valid_reg <= 1'b0;
      o_last_reg  <= 1'b0;
    end else begin
      if (in_fire) begin
        if (!col_reg[0]) pair_reg <= i_data;
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
      if (result_load) begin
        o_data_reg  <= vmax;
        o_last_reg  <= row_last && col_last;
        o_valid_reg <= 1'b1;
      end else if (out_fire) begin
        o_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: two instances (unsigned and signed compare) share one input stream;
// fixed frame vectors, latency/stall/reset sequences and random frames checked against a window-max model.
module tb_maxpool_stream;
  localparam int DW   = 8;
  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int WORD = DW * CH;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready = 1'b1;
  logic [WORD-1:0] i_data = '0;
  logic            i_ready_u, o_valid_u, o_last_u;
  logic            i_ready_s, o_valid_s, o_last_s;
  logic [WORD-1:0] o_data_u, o_data_s;

  always #5 clk = ~clk;

  maxpool_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_W(W), .IMG_H(H), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready_u),
    .o_valid(o_valid_u), .o_data(o_data_u), .o_last(o_last_u), .o_ready(o_ready));

  maxpool_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_W(W), .IMG_H(H), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready_s),
    .o_valid(o_valid_s), .o_data(o_data_s), .o_last(o_last_s), .o_ready(o_ready));

  typedef struct {
    logic [WORD-1:0] data;
    logic            last;
  } out_t;

  typedef struct {
    logic [NPIX-1:0][WORD-1:0] pix;
    logic [1:0][WORD-1:0]      eu;
    logic [1:0][WORD-1:0]      es;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;
  out_t exp_u[$], exp_s[$], cap_u[$], cap_s[$];
  out_t mon_e;
  logic [WORD-1:0] img [NPIX];
  int   pix_cnt = 0;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: store the frame, and at each bottom-right pixel take the max of the 2x2 window per lane.
  function automatic void model_accept(input logic [WORD-1:0] d);
    int r, c;
    out_t mu, ms;
    logic [DW-1:0] v [4];
    logic [DW-1:0] bu;
    logic signed [DW-1:0] bs;
    img[pix_cnt] = d;
    r = pix_cnt / W;
    c = pix_cnt % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      for (int l = 0; l < CH; l++) begin
        v[0] = img[(r-1)*W + c-1][l*DW +: DW];
        v[1] = img[(r-1)*W + c][l*DW +: DW];
        v[2] = img[r*W + c-1][l*DW +: DW];
        v[3] = d[l*DW +: DW];
        bu = v[0];
        bs = v[0];
        for (int k = 1; k < 4; k++) begin
          if (v[k] > bu) bu = v[k];
          if ($signed(v[k]) > bs) bs = v[k];
        end
        mu.data[l*DW +: DW] = bu;
        ms.data[l*DW +: DW] = bs;
      end
      mu.last = (pix_cnt == NPIX - 1);
      ms.last = mu.last;
      exp_u.push_back(mu);
      exp_s.push_back(ms);
    end
    pix_cnt = (pix_cnt + 1) % NPIX;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_u.delete();
      exp_s.delete();
      pix_cnt = 0;
    end else begin
      if (i_ready_s !== i_ready_u) check("ready_match", 32'(i_ready_s), 32'(i_ready_u));
      if (o_valid_u && o_ready) begin
        cap_u.push_back('{data: o_data_u, last: o_last_u});
        if (exp_u.size() == 0) check("unexpected_out_u", 32'(o_valid_u), 32'd0);
        else begin
          mon_e = exp_u.pop_front();
          check("stream_u", 32'({o_last_u, o_data_u}), 32'({mon_e.last, mon_e.data}));
        end
      end
      if (o_valid_s && o_ready) begin
        cap_s.push_back('{data: o_data_s, last: o_last_s});
        if (exp_s.size() == 0) check("unexpected_out_s", 32'(o_valid_s), 32'd0);
        else begin
          mon_e = exp_s.pop_front();
          check("stream_s", 32'({o_last_s, o_data_s}), 32'({mon_e.last, mon_e.data}));
        end
      end
      if (i_valid && i_ready_u) model_accept(i_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) o_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [WORD-1:0] d, input int gap);
    bit acc;
    int t;
    for (int g = 0; g < gap; g++) begin
      i_valid = 1'b0;
      step();
    end
    i_valid = 1'b1;
    i_data  = d;
    acc = 1'b0;
    t = 0;
    while (!acc) begin
      @(negedge clk);
      acc = i_ready_u;
      step();
      t++;
      if (!acc && t > 200) begin
        check("accept_timeout", 32'(t), 32'd0);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  initial begin
    logic [WORD-1:0] saved;
    // lane1 in the upper byte, lane0 in the lower byte; pixels in raster order
    vecs[0].pix = {16'h5007, 16'h4609, 16'h3C00, 16'h3204, 16'h2803, 16'h1E02, 16'h1405, 16'h0A01};
    vecs[0].eu  = {16'h5009, 16'h3C05};
    vecs[0].es  = {16'h5009, 16'h3C05};
    vecs[1].pix = {16'h0800, 16'h0700, 16'h01FE, 16'h8101, 16'h0600, 16'h0500, 16'h7F80, 16'h80FF};
    vecs[1].eu  = {16'h0800, 16'h81FF};
    vecs[1].es  = {16'h0800, 16'h7F01};
    vecs[2].pix = {16'h3228, 16'h641E, 16'h0A04, 16'h1403, 16'h9614, 16'hC80A, 16'h1E02, 16'h2801};
    vecs[2].eu  = {16'hC828, 16'h2804};
    vecs[2].es  = {16'h6428, 16'h2804};
    vecs[3].pix = {16'h0080, 16'h8000, 16'hFF00, 16'hFF00, 16'h0080, 16'h8000, 16'hFF00, 16'hFF00};
    vecs[3].eu  = {16'h8080, 16'hFF00};
    vecs[3].es  = {16'h0000, 16'hFF00};

    // reset state
    #2;
    check("rst_o_valid", 32'({o_valid_u, o_valid_s}), 32'd0);
    check("rst_i_ready", 32'({i_ready_u, i_ready_s}), 32'd3);
    check("rst_o_data_last", 32'({o_last_u, o_data_u}), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // one-cycle latency and o_valid drop after transfer with nothing new
    for (int i = 0; i < NPIX; i++) begin
      i_valid = 1'b1;
      i_data  = vecs[0].pix[i];
      step();
      if (i == 5) check("lat_out0", 32'({o_valid_u, o_last_u, o_data_u}), 32'({1'b1, 1'b0, 16'h3C05}));
      else if (i == 7) check("lat_out1", 32'({o_valid_u, o_last_u, o_data_u}), 32'({1'b1, 1'b1, 16'h5009}));
      else check("lat_idle", 32'(o_valid_u), 32'd0);
    end
    i_valid = 1'b0;
    repeat (3) step();

    // table-driven frames with a different gap length per record
    for (int v = 0; v < 4; v++) begin
      cap_u.delete();
      cap_s.delete();
      for (int i = 0; i < NPIX; i++) push(vecs[v].pix[i], v);
      repeat (3) step();
      check("tbl_count", 32'({cap_u.size(), cap_s.size()}), 32'({32'd2, 32'd2}));
      if (cap_u.size() == 2 && cap_s.size() == 2) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("tbl%0d_u%0d", v, k), 32'({cap_u[k].last, cap_u[k].data}), 32'({k == 1, vecs[v].eu[k]}));
          check($sformatf("tbl%0d_s%0d", v, k), 32'({cap_s[k].last, cap_s[k].data}), 32'({k == 1, vecs[v].es[k]}));
        end
      end
    end

    // downstream stall: output held, input refused, then stream resumes
    o_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(vecs[2].pix[i], 0);
    saved = o_data_u;
    check("stall_first_out", 32'(saved), 32'h2804);
    i_valid = 1'b1;
    i_data  = vecs[2].pix[6];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", 32'({o_valid_u, i_ready_u, o_last_u, o_data_u}), 32'({1'b1, 1'b0, 1'b0, saved}));
      step();
    end
    o_ready = 1'b1;
    push(vecs[2].pix[6], 0);
    push(vecs[2].pix[7], 0);
    repeat (3) step();

    // reset in the middle of row 1, then a fresh frame
    for (int i = 0; i < 7; i++) push(WORD'($urandom), 0);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_state", 32'({o_valid_u, o_valid_s, i_ready_u}), 32'b001);
      step();
    end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NPIX; i++) push(WORD'($urandom), 0);

    // random back-to-back frames with input gaps and random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 6 * NPIX; i++) push(WORD'($urandom), $urandom_range(0, 2));
    rand_rdy = 1'b0;
    o_ready = 1'b1;
    repeat (5) step();
    check("drain_empty", 32'({exp_u.size(), exp_s.size()}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
